// File: rtl/note_arbiter.sv
// note_arbiter: eight piano keys (C4..C5) share one square-wave divider.
// Keys are synchronised and debounced. The lowest pressed key wins, and its
// half-period limit is loaded into the divider that drives tone_out.
// When the note changes or the keys are released, the divider first runs to
// its next wrap, so tone_out never produces a runt high pulse.
// Build option: define OCTAVE_EN to add the octave_up input. When it is set,
// the limit loaded into the divider is halved.
module note_arbiter #(
   parameter int CLK_HZ       = 50000000,
   parameter int DEBOUNCE_CYC = 500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] keys,
   input  logic       enable,
`ifdef OCTAVE_EN
   input  logic       octave_up,
`endif
   output logic       tone_out,
   output logic [2:0] note_idx,
   output logic       note_valid
);

   localparam int SW = $clog2(DEBOUNCE_CYC);
   localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE_CYC - 1);

   // Half-period limits: CLK_HZ / (2 * f), evaluated at elaboration time.
   localparam logic [16:0] LIM_0 = 17'(CLK_HZ / (2 * 262));
   localparam logic [16:0] LIM_1 = 17'(CLK_HZ / (2 * 294));
   localparam logic [16:0] LIM_2 = 17'(CLK_HZ / (2 * 330));
   localparam logic [16:0] LIM_3 = 17'(CLK_HZ / (2 * 349));
   localparam logic [16:0] LIM_4 = 17'(CLK_HZ / (2 * 392));
   localparam logic [16:0] LIM_5 = 17'(CLK_HZ / (2 * 440));
   localparam logic [16:0] LIM_6 = 17'(CLK_HZ / (2 * 494));
   localparam logic [16:0] LIM_7 = 17'(CLK_HZ / (2 * 523));

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PLAY  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   function automatic logic [16:0] f_limit(input logic [2:0] idx);
      logic [16:0] lim;
      case (idx)
         3'd0:    lim = LIM_0;
         3'd1:    lim = LIM_1;
         3'd2:    lim = LIM_2;
         3'd3:    lim = LIM_3;
         3'd4:    lim = LIM_4;
         3'd5:    lim = LIM_5;
         3'd6:    lim = LIM_6;
         default: lim = LIM_7;
      endcase
      return lim;
   endfunction

   logic [7:0]    r_k_s1;
   logic [7:0]    r_k_s2;
   logic [7:0]    r_cand;
   logic [SW-1:0] r_stab;
   logic [7:0]    r_keys_db;

   state_t        r_state;
   logic [16:0]   r_cnt;
   logic [16:0]   r_limit;
   logic          r_tone;
   logic [2:0]    r_idx;

   state_t        w_state_nxt;
   logic [16:0]   w_cnt_nxt;
   logic [16:0]   w_limit_nxt;
   logic          w_tone_nxt;
   logic [2:0]    w_idx_nxt;
   logic          w_load;

   logic [2:0]    w_win_idx;
   logic          w_win_valid;
   logic          w_wrap;
   logic [16:0]   w_div_cnt;
   logic          w_div_tone;
   logic [16:0]   w_load_limit;
   logic          w_oct_change;

   // Two-flop synchroniser, then a stability counter that accepts the key vector.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_k_s1    <= '0;
         r_k_s2    <= '0;
         r_cand    <= '0;
         r_stab    <= '0;
         r_keys_db <= '0;
      end else begin
         r_k_s1 <= keys;
         r_k_s2 <= r_k_s1;
         if (r_k_s2 != r_cand) begin
            r_cand <= r_k_s2;
            r_stab <= '0;
         end else if (r_stab == STAB_MAX) begin
            r_keys_db <= r_cand;
         end else begin
            r_stab <= r_stab + SW'(1);
         end
      end
   end

   // Fixed priority: the lowest pressed key wins.
   always_comb begin
      w_win_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (r_keys_db[i]) w_win_idx = 3'(i);
      end
   end

   assign w_win_valid = |r_keys_db;
   assign w_wrap      = (r_cnt == r_limit);
   assign w_div_cnt   = w_wrap ? 17'd0 : r_cnt + 17'd1;
   assign w_div_tone  = w_wrap ? ~r_tone : r_tone;

`ifdef OCTAVE_EN
   logic r_oct_s1;
   logic r_oct_s2;
   logic r_oct_cur;

   // Synchronise octave_up and remember which octave the loaded limit uses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_oct_s1  <= 1'b0;
         r_oct_s2  <= 1'b0;
         r_oct_cur <= 1'b0;
      end else begin
         r_oct_s1 <= octave_up;
         r_oct_s2 <= r_oct_s1;
         if (w_load) r_oct_cur <= r_oct_s2;
      end
   end

   assign w_load_limit = r_oct_s2 ? (f_limit(w_win_idx) >> 1) : f_limit(w_win_idx);
   assign w_oct_change = (r_oct_s2 != r_oct_cur);
`else
   assign w_load_limit = f_limit(w_win_idx);
   assign w_oct_change = 1'b0;
`endif

   // State register and the shared divider.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_limit <= '0;
         r_tone  <= 1'b0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_limit <= w_limit_nxt;
         r_tone  <= w_tone_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Next state. A note change or release drains the divider to its next wrap
   // before anything is reloaded. Clearing enable overrides every transition.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_limit_nxt = r_limit;
      w_tone_nxt  = r_tone;
      w_idx_nxt   = r_idx;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_tone_nxt = 1'b0;
            w_cnt_nxt  = 17'd0;
            if (w_win_valid) begin
               w_load      = 1'b1;
               w_state_nxt = S_PLAY;
            end
         end
         S_PLAY: begin
            w_cnt_nxt  = w_div_cnt;
            w_tone_nxt = w_div_tone;
            if (!w_win_valid && !r_tone) begin
               w_state_nxt = S_IDLE;
               w_tone_nxt  = 1'b0;
               w_cnt_nxt   = 17'd0;
            end else if (!w_win_valid || (w_win_idx != r_idx) || w_oct_change) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_cnt_nxt  = w_div_cnt;
            w_tone_nxt = w_div_tone;
            if (w_wrap) begin
               w_tone_nxt = 1'b0;
               w_cnt_nxt  = 17'd0;
               if (w_win_valid) begin
                  w_load      = 1'b1;
                  w_state_nxt = S_PLAY;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_tone_nxt  = 1'b0;
            w_cnt_nxt   = 17'd0;
         end
      endcase
      if (!enable) begin
         w_state_nxt = S_IDLE;
         w_tone_nxt  = 1'b0;
         w_cnt_nxt   = 17'd0;
         w_load      = 1'b0;
      end
      if (w_load) begin
         w_idx_nxt   = w_win_idx;
         w_limit_nxt = w_load_limit;
         w_cnt_nxt   = 17'd0;
      end
   end

   assign tone_out   = r_tone;
   assign note_idx   = r_idx;
   assign note_valid = (r_state != S_IDLE);

endmodule

// File: tb/tb_note_arbiter.sv
// Testbench for note_arbiter. A small clock rate keeps half-periods short.
// The reference model predicts every change of {tone_out, note_valid, note_idx}
// together with its cycle number. A monitor matches each change the DUT makes
// against those predictions.
module tb_note_arbiter;
   localparam int CLK_HZ = 50000;
   localparam int DB     = 8;
   localparam int EW     = 37;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic [7:0] keys   = 8'h00;
   logic       enable = 1'b0;
`ifdef OCTAVE_EN
   logic       octave_up = 1'b0;
`endif
   logic       tone_out;
   logic [2:0] note_idx;
   logic       note_valid;

   int n_cmp = 0;
   int n_bad = 0;
   logic [EW-1:0] exp_q[$];
   int unsigned cyc = 0;

   note_arbiter #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DB)) dut (
      .clk(clk),
      .reset(rst_n),
      .keys(keys),
      .enable(enable),
`ifdef OCTAVE_EN
      .octave_up(octave_up),
`endif
      .tone_out(tone_out),
      .note_idx(note_idx),
      .note_valid(note_valid)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lim_of(input int i);
      case (i)
         0: return CLK_HZ / (2 * 262);
         1: return CLK_HZ / (2 * 294);
         2: return CLK_HZ / (2 * 330);
         3: return CLK_HZ / (2 * 349);
         4: return CLK_HZ / (2 * 392);
         5: return CLK_HZ / (2 * 440);
         6: return CLK_HZ / (2 * 494);
         default: return CLK_HZ / (2 * 523);
      endcase
   endfunction

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out waiting for the DUT", name);
   endtask

   // Reference model. The debounced vector takes a value once the last DB+1
   // synchronised samples agree. The tone level is derived from the number of
   // cycles elapsed since the last limit load.
   int          m_mode = 0;   // 0 idle, 1 play, 2 drain
   int          m_idx  = 0;
   int          m_lim  = 0;
   longint      m_t0   = 0;
   longint      m_t;
   logic [7:0]  m_s1 = 0, m_s2 = 0, m_db = 0;
   logic [7:0]  m_hist[$];
   logic [4:0]  m_last = 0;
   logic [4:0]  m_out;
   bit          m_wv, m_wrap, m_pre_tone, m_eq, m_tone, m_oct_chg;
   int          m_win;
   logic        m_os1 = 0, m_os2 = 0, m_ocur = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; m_idx = 0; m_lim = 0; m_t0 = 0;
         m_s1 = 0; m_s2 = 0; m_db = 0; m_last = 0;
         m_os1 = 0; m_os2 = 0; m_ocur = 0;
         m_hist.delete();
         for (int i = 0; i < DB + 1; i++) m_hist.push_back(8'h00);
         exp_q.delete();
      end else begin
         m_t  = longint'(cyc) + 1;
         m_wv = (m_db != 0);
         m_win = lowest(m_db);
         m_wrap = 0;
         m_pre_tone = 0;
         if (m_mode != 0) begin
            m_wrap     = ((m_t - m_t0) % (m_lim + 1)) == 0;
            m_pre_tone = (((m_t - 1 - m_t0) / (m_lim + 1)) % 2) == 1;
         end
`ifdef OCTAVE_EN
         m_oct_chg = (m_os2 != m_ocur);
`else
         m_oct_chg = 0;
`endif
         if (!enable) m_mode = 0;
         else if (m_mode == 0 || (m_mode == 2 && m_wrap)) begin
            if (m_wv) begin
               m_idx  = m_win;
               m_lim  = m_os2 ? (lim_of(m_win) >> 1) : lim_of(m_win);
               m_ocur = m_os2;
               m_t0   = m_t;
               m_mode = 1;
            end else m_mode = 0;
         end else if (m_mode == 1) begin
            if (!m_wv && !m_pre_tone) m_mode = 0;
            else if (!m_wv || m_win != m_idx || m_oct_chg) m_mode = 2;
         end
         // Synchroniser and sliding-window debounce.
         m_hist.push_back(m_s2);
         if (m_hist.size() > DB + 1) void'(m_hist.pop_front());
         m_eq = 1;
         foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) m_eq = 0;
         if (m_eq) m_db = m_hist[0];
         m_s2 = m_s1;
         m_s1 = keys;
`ifdef OCTAVE_EN
         m_os2 = m_os1;
         m_os1 = octave_up;
`endif
         m_tone = (m_mode != 0) && ((((m_t - m_t0) / (m_lim + 1)) % 2) == 1);
         m_out  = {m_tone, (m_mode != 0), 3'(m_idx)};
         if (m_out != m_last) exp_q.push_back({32'(m_t), m_out});
         m_last = m_out;
      end
   end

   // Monitor: each change of the DUT outputs consumes one predicted event.
   logic [4:0]    d_last = 0;
   logic [4:0]    d_now;
   logic [EW-1:0] d_got, d_want;

   always @(negedge clk) begin
      if (!rst_n) d_last = 0;
      else begin
         d_now = {tone_out, note_valid, note_idx};
         if (d_now !== d_last) begin
            d_got = {cyc, d_now};
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL sb_unexpected: got cyc=%0d tone=%0b valid=%0b idx=%0d, expected no change",
                        cyc, tone_out, note_valid, note_idx);
            end else begin
               d_want = exp_q.pop_front();
               if (d_got !== d_want) begin
                  n_bad++;
                  $display("FAIL sb_event: got cyc=%0d tone=%0b valid=%0b idx=%0d, expected cyc=%0d tone=%0b valid=%0b idx=%0d",
                           cyc, tone_out, note_valid, note_idx,
                           d_want[36:5], d_want[4], d_want[3], d_want[2:0]);
               end
            end
            d_last = d_now;
         end
      end
   end

   // Driver tasks.
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_tone(input logic lvl, input int max, input string name);
      int n = 0;
      while (tone_out !== lvl && n < max) begin @(negedge clk); n++; end
      if (tone_out !== lvl) timeout(name);
   endtask

   task automatic wait_valid(input logic lvl, input int max, input string name);
      int n = 0;
      while (note_valid !== lvl && n < max) begin @(negedge clk); n++; end
      if (note_valid !== lvl) timeout(name);
   endtask

   task automatic wait_idx(input logic [2:0] idx, input int max, input string name);
      int n = 0;
      while (note_idx !== idx && n < max) begin @(negedge clk); n++; end
      if (note_idx !== idx) timeout(name);
   endtask

   task automatic run_len(input logic lvl, output int n);
      n = 1;
      forever begin
         @(negedge clk);
         if (tone_out !== lvl || n > 2000) break;
         n++;
      end
   endtask

   task automatic measure_high(output int n);
      wait_tone(1'b0, 400, "meas_low_wait");
      wait_tone(1'b1, 400, "meas_high_wait");
      run_len(1'b1, n);
   endtask

   int len, lat, cnt, r, nt;

   initial begin
      // Reset state.
      step(3);
      check("reset_tone", tone_out, 0);
      check("reset_valid", note_valid, 0);
      check("reset_idx", note_idx, 0);
      #2 rst_n = 1'b1;

      // Single key and its half-period.
      step(2);
      enable = 1'b1;
      keys   = 8'h02;
      lat = 0;
      while (!note_valid && lat < 40) begin @(negedge clk); lat++; end
      check("single_latency_le12", (lat <= 12), 1);
      check("single_idx", note_idx, 1);
      measure_high(len);
      check("single_high", len, lim_of(1) + 1);
      run_len(1'b0, len);
      check("single_low", len, lim_of(1) + 1);

      // Priority, then a note change through DRAIN.
      keys = 8'h12;
      step(30);
      check("prio_idx", note_idx, 1);
      keys = 8'h10;
      wait_idx(3'd4, 400, "change_idx_wait");
      check("change_idx", note_idx, 4);
      measure_high(len);
      check("change_high", len, lim_of(4) + 1);

      // Release while high: the high level keeps its full length.
      keys = 8'h02;
      wait_idx(3'd1, 400, "back_idx_wait");
      wait_tone(1'b0, 400, "rel_low_wait");
      wait_tone(1'b1, 400, "rel_high_wait");
      keys = 8'h00;
      run_len(1'b1, len);
      check("release_high_full", len, lim_of(1) + 1);
      check("release_valid_off", note_valid, 0);

      // Release while low: IDLE within DB+4 cycles.
      keys = 8'h02;
      wait_valid(1'b1, 40, "rel2_valid_wait");
      wait_tone(1'b1, 400, "rel2_high_wait");
      wait_tone(1'b0, 400, "rel2_low_wait");
      keys = 8'h00;
      lat = 0;
      while (note_valid && lat < 100) begin @(negedge clk); lat++; end
      check("release_low_latency", (lat <= DB + 4), 1);

      // Bouncing key never reaches the debounced vector.
      step(5);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         keys = keys ^ 8'h01;
         for (int j = 0; j < 2; j++) begin @(negedge clk); if (note_valid) cnt++; end
      end
      for (int j = 0; j < 15; j++) begin @(negedge clk); if (note_valid) cnt++; end
      check("bounce_valid_cycles", cnt, 0);

      // Mute during play.
      keys = 8'h08;
      wait_valid(1'b1, 40, "mute_valid_wait");
      step(40);
      enable = 1'b0;
      @(posedge clk);
      #1;
      check("mute_tone", tone_out, 0);
      check("mute_valid", note_valid, 0);
      @(negedge clk);
      enable = 1'b1;
      step(50);

`ifdef OCTAVE_EN
      // Octave shift halves the loaded limit; clearing it reloads at the wrap.
      keys = 8'h00;
      wait_valid(1'b0, 400, "oct_idle_wait");
      octave_up = 1'b1;
      step(5);
      keys = 8'h20;
      wait_valid(1'b1, 40, "oct_valid_wait");
      measure_high(len);
      check("oct_high_up", len, (lim_of(5) >> 1) + 1);
      octave_up = 1'b0;
      step(100);
      measure_high(len);
      check("oct_high_down", len, lim_of(5) + 1);
`endif

      // Randomised key patterns, enables and bounces.
      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 9);
         if (r < 2) keys = 8'h00;
         else if (r < 7) keys = 8'(1 << $urandom_range(0, 7));
         else keys = 8'($urandom_range(0, 255));
         enable = ($urandom_range(0, 9) != 0);
`ifdef OCTAVE_EN
         if ($urandom_range(0, 3) == 0) octave_up = ~octave_up;
`endif
         if ($urandom_range(0, 4) == 0) begin
            nt = $urandom_range(2, 8);
            for (int j = 0; j < nt; j++) begin
               keys = keys ^ 8'(1 << $urandom_range(0, 7));
               step($urandom_range(1, 3));
            end
         end
         step($urandom_range(5, 300));
      end

      // Reset in the middle of a high tone.
      enable = 1'b1;
      keys   = 8'h02;
      wait_tone(1'b0, 600, "rst_low_wait");
      wait_tone(1'b1, 600, "rst_high_wait");
      #2;
      check("pre_reset_queue_empty", exp_q.size(), 0);
      rst_n = 1'b0;
      #1;
      check("async_reset_tone", tone_out, 0);
      check("async_reset_valid", note_valid, 0);
      check("async_reset_idx", note_idx, 0);
      step(3);
      check("held_reset_tone", tone_out, 0);
      #2 rst_n = 1'b1;
      step(5);
      check("post_reset_tone", tone_out, 0);
      check("post_reset_valid", note_valid, 0);
      step(300);
      keys = 8'h00;
      step(300);
      #2;
      check("final_queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/note_arbiter.md
Name: note_arbiter

Overview:
- Shares one square-wave tone divider among eight piano keys (C4..C5).
- Synchronises and debounces the key inputs, then picks one note by fixed priority.
- Loads that note's half-period limit into the shared divider and drives the speaker pin.
- Note changes and releases are sequenced so the output never emits a runt high pulse.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz.
DEBOUNCE_CYC, 500000, cycles the synchronised key vector must stay stable before it is accepted (10 ms at 50 MHz); minimum 2.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
keys  input  8  raw key levels, bit0=C4, bit1=D4, bit2=E4, bit3=F4, bit4=G4, bit5=A4, bit6=B4, bit7=C5; 1=pressed.
enable  input  1  synchronous play enable; 0 mutes and returns to IDLE.
tone_out  output  1  square wave to the speaker pin.
note_idx  output  3  index of the note currently sounding.
note_valid  output  1  1 while a note is sounding (states PLAY/DRAIN).

Behaviour:
- Reset (reset=0, async): tone_out=0, note_idx=0, note_valid=0; divider counter=0; sync/debounce registers=0; state=IDLE.
- Sync and debounce:
  - keys pass through 2 flops.
  - If the synced vector differs from the held candidate: the candidate is reloaded and the stable counter is cleared.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYC-1; on reaching it, keys_db takes the candidate.
  - An input edge held stable reaches keys_db within DEBOUNCE_CYC+3 cycles.
- Arbitration: winner = lowest set bit of keys_db; win_valid = |keys_db.
- Limit table: LIMIT = CLK_HZ/(2*f), integer division, computed at elaboration, 17-bit.
  - f = 262, 294, 330, 349, 392, 440, 494, 523 Hz.
  - Limits at 50 MHz: 95419, 85034, 75757, 71633, 63775, 56818, 50607, 47801.
- Divider: counter increments each cycle in PLAY/DRAIN. At counter==limit ("wrap"), counter returns to 0 and tone_out toggles. Half-period = limit+1 cycles.
- FSM states: IDLE, PLAY, DRAIN.
  - IDLE:
    - tone_out=0, counter held 0, note_valid=0.
    - If enable && win_valid: note_idx<=winner, limit<=LIMIT[winner], counter<=0, go PLAY.
    - note_valid=1 from the next cycle; first tone_out rise at the first wrap.
  - PLAY:
    - Divider runs.
    - If !win_valid and tone_out==0: go IDLE next cycle.
    - If !win_valid and tone_out==1: go DRAIN.
    - If winner!=note_idx: go DRAIN.
  - DRAIN:
    - Divider runs with the old limit until the next wrap.
    - At that wrap: tone_out<=0 (forced, regardless of prior level) and counter<=0.
    - Then: if win_valid, note_idx<=winner (sampled at the wrap), load its limit, go PLAY; else go IDLE.
    - Winner changes during DRAIN only affect the value sampled at the wrap.
    - Guarantees that no high pulse is shorter than the old note's half-period.
- enable=0 in any state:
  - Next cycle: tone_out=0, counter=0, note_valid=0, state=IDLE.
  - Overrides all other transitions.
- Reset mid-operation: immediate async return to reset values.
- Simultaneous presses: lowest index wins. A higher-index key pressed alongside a sounding lower-index key is ignored.

Optional Feature:
OCTAVE_EN:
- Defined:
  - Adds input port octave_up (1 bit), sampled through the same 2-flop synchroniser, not debounced.
  - When octave_up=1 at a limit load (IDLE->PLAY or DRAIN->PLAY), the loaded limit = LIMIT[winner]>>1.
  - A change of octave_up while in PLAY is treated as a note change: enter DRAIN, reload at the wrap.
- Undefined: no octave_up port; limits always come from the table unshifted.

Test Plan:
1. Reset: drive reset=0 mid-tone with tone_out=1 -> tone_out, note_valid, note_idx all 0 in the same cycle. Release reset -> IDLE, tone_out stays 0.
2. Single key (DEBOUNCE_CYC=8): enable=1, keys=8'h02 -> note_valid=1, note_idx=1 within 12 cycles. tone_out high/low segments exactly 85035 cycles each.
3. Priority/change: keys=8'h12 -> note_idx=1. Clear bit1 -> tone continues to the next wrap; tone_out=0 there; note_idx=4; then segments of 63776 cycles. No high segment <85035.
4. Release: release all keys while tone_out=1 -> high lasts the full 85035 cycles, then IDLE, note_valid=0. Release while tone_out=0 -> IDLE within DEBOUNCE_CYC+4 cycles of release.
5. Bounce/mute: toggle bit0 every 2 cycles for 20 cycles (DEBOUNCE_CYC=8) -> note_valid stays 0. During play, enable=0 -> tone_out=0 and note_valid=0 next cycle.
6. OCTAVE_EN: keys=8'h20, octave_up=1 -> half-period 28410 cycles. Toggle octave_up to 0 -> reload at the next wrap to 56819.
